// File: rtl/sha3_256_req_ctrl.sv
// sha3_256_req_ctrl: byte-stream packer and digest streamer for sha3_256; SHA3_REQ_TIMEOUT_EN adds a HASH watchdog
module sha3_256_req_ctrl #(
  parameter int MAX_BYTES      = 1184,
  parameter int LEN_W          = 14,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [7:0]             s_data,
  input  logic                   s_last,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [7:0]             m_data,
  output logic                   m_last,
  output logic                   h_enable,
  output logic [8*MAX_BYTES-1:0] h_in,
  output logic [LEN_W-1:0]       h_input_len,
  input  logic [255:0]           h_digest,
  input  logic                   h_done,
  output logic                   busy,
  output logic                   err
);
  localparam int CW = $clog2(MAX_BYTES + 1);
  typedef enum logic [1:0] {LOAD, HASH, OUT} state_t;
  state_t state, state_d;
  logic [CW-1:0] cnt;
  logic [4:0]    j;
  logic [255:0]  dig;
  logic          acc, full, done_out, tmo;
  assign acc      = s_valid & s_ready;
  assign full     = cnt == CW'(MAX_BYTES - 1);
  assign done_out = m_valid & m_ready & m_last;
`ifdef SHA3_REQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
  assign tmo = state == HASH && !h_done && tcnt == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk)
    tcnt <= (rst || state != HASH) ? '0 : tcnt + 1'b1;
`else
  assign tmo = 1'b0;
`endif
  always_comb begin
    state_d = state;
    s_ready = state == LOAD;
    m_valid = state == OUT;
    busy    = state != LOAD;
    m_last  = m_valid && j == 5'd31;
    m_data  = m_valid ? dig[{j, 3'b000} +: 8] : 8'd0;
    if (state == LOAD && acc && (s_last || full)) state_d = HASH;
    if (state == HASH && h_done) state_d = OUT;
    if (tmo || done_out) state_d = LOAD;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= LOAD;
      cnt         <= '0;
      h_in        <= '0;
      h_input_len <= '0;
      h_enable    <= 1'b0;
      err         <= 1'b0;
      dig         <= '0;
      j           <= '0;
    end else begin
      state <= state_d;
      err   <= tmo;
      if (acc) begin
        h_in[{cnt, 3'b000} +: 8] <= s_data;
        cnt                      <= cnt + 1'b1;
      end
      if (acc && state_d == HASH) begin
        h_input_len <= (LEN_W'(cnt) + LEN_W'(1)) << 3;
        h_enable    <= 1'b1;
        err         <= full & ~s_last;
      end
      if (state == HASH && h_done) begin
        dig      <= h_digest;
        h_enable <= 1'b0;
        j        <= '0;
      end
      if (m_valid && m_ready) j <= j + 1'b1;
      // a finished or abandoned request leaves a clean buffer for the next message
      if (tmo || done_out) begin
        h_enable    <= 1'b0;
        h_in        <= '0;
        cnt         <= '0;
        h_input_len <= '0;
      end
    end
  end
endmodule

// File: tb/tb_sha3_256_req_ctrl.sv
// tb_sha3_256_req_ctrl: randomized directed bench with a byte-array model of the packed bus and digest order
module tb_sha3_256_req_ctrl;
  localparam int MB = 1184;
  logic clk = 0, rst = 1;
  logic s_valid = 0, s_last = 0, m_ready = 0, h_done = 0;
  logic [7:0] s_data = 0;
  logic s_ready, m_valid, m_last, h_enable, busy, err;
  logic [7:0] m_data;
  logic [8*MB-1:0] h_in, exp_in;
  logic [13:0] h_input_len;
  logic [255:0] h_digest = 0;
  logic [7:0] db [32];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  sha3_256_req_ctrl #(.MAX_BYTES(MB), .LEN_W(14), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .h_enable(h_enable),
    .h_in(h_in), .h_input_len(h_input_len), .h_digest(h_digest), .h_done(h_done), .busy(busy), .err(err));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic send_msg(input int n, input bit last);
    exp_in = '0;
    for (int i = 0; i < n; i++) begin
      s_valid = 1;
      s_data  = 8'($urandom);
      s_last  = last && i == n - 1;
      exp_in[8*i +: 8] = s_data;
      chk("s_ready_load", s_ready, 1);
      step();
    end
    s_valid = 0;
    s_last  = 0;
    chk("enable_t1", h_enable, 1);
    chk("busy_t1", busy, 1);
    chk("s_ready_hash", s_ready, 0);
    chk("input_len", h_input_len, 64'(8 * n));
    chk("h_in_packed", h_in === exp_in, 1);
    chk("err_t1", err, (!last && n == MB) ? 1 : 0);
  endtask
  task automatic hash_and_stream(input int d, input bit toggle);
    logic [3:0] pat = 4'b1001;
    int j = 0;
    repeat (d) begin
      step();
      chk("err_low", err, 0);
      chk("enable_hold", h_enable, 1);
      chk("h_in_stable", h_in === exp_in, 1);
    end
    for (int k = 0; k < 32; k++) begin
      db[k] = 8'($urandom);
      h_digest[8*k +: 8] = db[k];
    end
    h_done = 1;
    step();
    h_done = 0;
    h_digest = {8{$urandom}};
    chk("m_valid_d1", m_valid, 1);
    chk("enable_drop", h_enable, 0);
    for (int c = 0; c < 200 && j < 32; c++) begin
      m_ready = toggle ? pat[c % 4] : 1'b1;
      chk("m_valid", m_valid, 1);
      chk("m_data", m_data, db[j]);
      chk("m_last", m_last, j == 31);
      @(posedge clk);
      if (m_ready) j++;
      @(negedge clk);
    end
    m_ready = 0;
    chk("stream_count", 64'(j), 32);
    chk("s_ready_back", s_ready, 1);
    chk("m_valid_off", m_valid, 0);
    chk("busy_off", busy, 0);
    chk("h_in_cleared", h_in === '0, 1);
    chk("len_cleared", h_input_len, 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_enable", h_enable, 0);
    chk("rst_err", err, 0);
    chk("rst_len", h_input_len, 0);
    chk("rst_h_in", h_in === '0, 1);
    rst = 0;
    send_msg(32, 1);
    hash_and_stream($urandom_range(1, 6), 0);
    send_msg(MB, 1);
    hash_and_stream($urandom_range(1, 6), 0);
    repeat (3) begin
      send_msg($urandom_range(1, 64), 1);
      hash_and_stream($urandom_range(1, 6), 1);
    end
    send_msg(MB, 0);
    s_valid = 1;
    s_data  = 8'hA5;
    step();
    s_valid = 0;
    chk("ovf_s_ready", s_ready, 0);
    chk("ovf_err_pulse_end", err, 0);
    chk("ovf_h_in", h_in === exp_in, 1);
    chk("ovf_len", h_input_len, 8 * MB);
    hash_and_stream($urandom_range(1, 6), 1);
    send_msg(32, 1);
    repeat (4) step();
    rst = 1;
    step();
    chk("mid_rst_enable", h_enable, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_s_ready", s_ready, 1);
    chk("mid_rst_h_in", h_in === '0, 1);
    rst = 0;
    send_msg(32, 1);
    hash_and_stream($urandom_range(1, 6), 0);
`ifdef SHA3_REQ_TIMEOUT_EN
    begin
      int hc = 0;
      bit saw_valid = 0;
      send_msg(32, 1);
      while (!err && hc < 100) begin
        if (busy) hc++;
        if (m_valid) saw_valid = 1;
        step();
      end
      chk("tmo_cycles", 64'(hc), 16);
      chk("tmo_no_valid", saw_valid, 0);
      chk("tmo_s_ready", s_ready, 1);
      chk("tmo_enable", h_enable, 0);
      chk("tmo_h_in", h_in === '0, 1);
      step();
      chk("tmo_err_pulse", err, 0);
    end
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
